// File: rtl/hub75_pkg.sv
// ---------------------------------------------------------------------------
// hub75_pkg : shared pixel width and SPI transmitter state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hub75_pkg;

  localparam int PIXEL_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_half_tick.sv
// ---------------------------------------------------------------------------
// spi_half_tick : half-period counter, one-cycle tick every HALF_PERIOD cycles
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_half_tick #(
  parameter int HALF_PERIOD = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == C_LAST);

  // Disabled counter parks at zero so every enabled phase starts a full half period.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_tx.sv
// ---------------------------------------------------------------------------
// spi_master_tx : 16-bit MSB-first SPI transmitter with receiver resync phase
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_master_tx
  import hub75_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int SYNC_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   spi_clk,
  output logic                   spi_mosi,
  output logic                   spi_reset,
  output logic                   busy
);

  localparam int SW = $clog2(SYNC_CYCLES + 1);
  localparam logic [SW-1:0] C_SYNC_LAST = SW'(SYNC_CYCLES);

  state_e                 state_q;
  logic [PIXEL_WIDTH-1:0] shreg_q;
  logic [3:0]             bit_q;
  logic [SW-1:0]          sync_cnt_q;
  logic                   sclk_q;
  logic                   mosi_q;
  logic                   sreset_q;

  logic w_tick;
  logic w_last_bit;
  logic w_accept;

  spi_half_tick #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_half_tick (
    .clock (clock),
    .reset (reset),
    .enable(state_q != ST_IDLE),
    .tick  (w_tick)
  );

  // Final cycle of bit 0's high phase: the only SHIFT cycle open to a new word.
  assign w_last_bit = (state_q == ST_SHIFT) && sclk_q && (bit_q == 4'd0) && w_tick;
  assign in_ready   = (state_q == ST_IDLE) || w_last_bit;
  assign w_accept   = in_valid && in_ready;

  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_reset = sreset_q;
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_SYNC;
      shreg_q    <= '0;
      bit_q      <= 4'd0;
      sync_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      sreset_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (w_tick) begin
            if (!sclk_q) begin
              sclk_q     <= 1'b1;
              sync_cnt_q <= sync_cnt_q + SW'(1);
            end else begin
              sclk_q <= 1'b0;
              if (sync_cnt_q == C_SYNC_LAST) begin
                state_q  <= ST_IDLE;
                sreset_q <= 1'b0;
              end
            end
          end
        end

        ST_IDLE: begin
          if (w_accept) begin
            shreg_q <= in_data;
            mosi_q  <= in_data[PIXEL_WIDTH-1];
            bit_q   <= 4'd15;
            state_q <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_q == 4'd0) begin
                if (w_accept) begin
                  shreg_q <= in_data;
                  mosi_q  <= in_data[PIXEL_WIDTH-1];
                  bit_q   <= 4'd15;
                end else begin
                  state_q <= ST_IDLE;
                end
              end else begin
                bit_q   <= bit_q - 4'd1;
                shreg_q <= {shreg_q[PIXEL_WIDTH-2:0], 1'b0};
                mosi_q  <= shreg_q[PIXEL_WIDTH-2];
              end
            end
          end
        end

        default: state_q <= ST_SYNC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_master_tx : directed bench with a receiver model for spi_master_tx
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_master_tx;

  logic        clock = 1'b0;
  logic        rst_n, rst1_n;
  logic [15:0] in_data, in_data1;
  logic        in_valid, in_valid1;
  logic        in_ready, spi_clk, spi_mosi, spi_reset, busy;
  logic        in_ready1, spi_clk1, spi_mosi1, spi_reset1, busy1;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  spi_master_tx #(.HALF_PERIOD(2), .SYNC_CYCLES(4)) dut (
    .clock(clock), .reset(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_reset(spi_reset), .busy(busy)
  );

  spi_master_tx #(.HALF_PERIOD(1), .SYNC_CYCLES(4)) dut1 (
    .clock(clock), .reset(rst1_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .spi_clk(spi_clk1), .spi_mosi(spi_mosi1),
    .spi_reset(spi_reset1), .busy(busy1)
  );

  // Receiver model for the HALF_PERIOD=2 instance
  int          cyc = 0;
  int          rises_total = 0;
  int          rise_log[$];
  logic [15:0] words[$];
  logic [15:0] rx_sh = '0;
  logic [15:0] rx_word = '0;
  int          rx_cnt = 0;
  logic        prev_clk = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
      rises_total++;
      rise_log.push_back(cyc);
    end
    if (spi_reset !== 1'b0) begin
      rx_sh   = '0;
      rx_cnt  = 0;
      rx_word = '0;
    end else if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
      rx_sh = {rx_sh[14:0], spi_mosi};
      rx_cnt++;
      if (rx_cnt == 16) begin
        rx_word = rx_sh;
        words.push_back(rx_sh);
        rx_cnt = 0;
      end
    end
    prev_clk = spi_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_words(input string tag, input int target);
    int n = 0;
    while (words.size() < target && n < 400) begin
      step();
      n++;
    end
    check(tag, words.size(), target);
    repeat (3) step();
  endtask

  task automatic wait_sync_end(input string tag);
    int n = 0;
    while (spi_reset && n < 200) begin
      step();
      n++;
    end
    check(tag, {31'd0, spi_reset}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, nw, r0, bad, ready_cnt, ready_i;
    logic ready_clk;
    logic [33:0] c1, m1;

    rst_n = 1'b0; rst1_n = 1'b0;
    in_valid = 1'b0; in_valid1 = 1'b0;
    in_data = '0; in_data1 = '0;
    repeat (3) step();

    check("rst_spi_clk",   {31'd0, spi_clk},   32'd0);
    check("rst_spi_mosi",  {31'd0, spi_mosi},  32'd0);
    check("rst_spi_reset", {31'd0, spi_reset}, 32'd1);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd1);

    // SYNC phase after release
    rst_n = 1'b1;
    n = 0;
    while (spi_reset && n < 100) begin
      n++;
      step();
    end
    check("sync_cycles",   n,                  16);
    check("sync_rises",    rises_total,        4);
    check("sync_end_clk",  {31'd0, spi_clk},   32'd0);
    check("sync_end_rdy",  {31'd0, in_ready},  32'd1);
    check("sync_end_busy", {31'd0, busy},      32'd0);

    // Single word
    rise_log.delete();
    nw = words.size();
    in_data = 16'hA5C3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    c0 = cyc;
    check("lat_mosi", {31'd0, spi_mosi}, 32'd1);
    check("lat_clk",  {31'd0, spi_clk},  32'd0);
    wait_words("a5c3_done", nw + 1);
    check("a5c3_word",    words[nw],         16'hA5C3);
    check("a5c3_latency", rise_log[0] - c0,  2);
    check("a5c3_rises",   rise_log.size(),   16);
    check("a5c3_clk_low", {31'd0, spi_clk},  32'd0);
    check("a5c3_busy",    {31'd0, busy},     32'd0);

    // Back-to-back words
    rise_log.delete();
    nw = words.size();
    in_data = 16'hFFFF; in_valid = 1'b1;
    step();
    in_data = 16'h0001;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("b2b_ready_seen", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    wait_words("b2b_done", nw + 2);
    check("b2b_word0", words[nw],     16'hFFFF);
    check("b2b_word1", words[nw + 1], 16'h0001);
    check("b2b_rises", rise_log.size(), 32);
    bad = 0;
    for (int i = 1; i < rise_log.size(); i++)
      if (rise_log[i] - rise_log[i-1] != 4) bad++;
    check("b2b_gaps", bad, 0);

    // Input changes mid-word are ignored
    nw = words.size();
    in_data = 16'h3C96; in_valid = 1'b1;
    step();
    ready_cnt = 0; ready_i = -1; ready_clk = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (busy && in_ready) begin
        ready_cnt++;
        ready_i   = i;
        ready_clk = spi_clk;
      end
      in_data  = 16'($urandom);
      in_valid = (i < 20);
      step();
    end
    in_valid = 1'b0;
    check("mid_ready_count", ready_cnt, 1);
    check("mid_ready_pos",   ready_i,   63);
    check("mid_ready_clk",   {31'd0, ready_clk}, 32'd1);
    check("mid_word_count",  words.size(), nw + 1);
    check("mid_word",        words[nw], 16'h3C96);

    // Reset in the middle of a word
    rise_log.delete();
    nw = words.size();
    in_data = 16'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (rise_log.size() < 7 && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("abort_7th_rise", rise_log.size(), 7);
    rst_n = 1'b0;
    r0 = rises_total;
    repeat (2) step();
    check("abort_no_rise",   rises_total,        r0);
    check("abort_clk",       {31'd0, spi_clk},   32'd0);
    check("abort_spi_reset", {31'd0, spi_reset}, 32'd1);
    check("abort_rx_word",   rx_word,            16'h0000);
    check("abort_no_word",   words.size(),       nw);
    rst_n = 1'b1;
    wait_sync_end("abort_sync_end");
    check("abort_sync_rises", rises_total - r0, 4);
    in_data = 16'h00FF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_words("resync_done", nw + 1);
    check("resync_word", words[nw], 16'h00FF);

    // HALF_PERIOD = 1 instance
    rst1_n = 1'b1;
    n = 0;
    while (spi_reset1 && n < 100) begin
      step();
      n++;
    end
    check("hp1_sync_end", {31'd0, in_ready1}, 32'd1);
    in_data1 = 16'h8000; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      c1[i] = spi_clk1;
      m1[i] = spi_mosi1;
      step();
    end
    check("hp1_first_clk",  {31'd0, c1[0]}, 32'd0);
    check("hp1_first_mosi", {31'd0, m1[0]}, 32'd1);
    check("hp1_first_rise", {31'd0, c1[1]}, 32'd1);
    bad = 0;
    for (int i = 0; i < 34; i++)
      if (c1[i] !== ((i < 32) ? logic'(i % 2) : 1'b0)) bad++;
    check("hp1_clk_pattern", bad, 0);
    bad = 0;
    for (int i = 0; i < 34; i++)
      if (m1[i] !== (i < 2)) bad++;
    check("hp1_mosi_pattern", bad, 0);
    check("hp1_idle_busy", {31'd0, busy1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_master_tx.md
SPI_MASTER_TX -- requirements
Module: spi_master_tx

Interface
Parameters:
REQ-001 HALF_PERIOD, 2, clock cycles per spi_clk half period; legal range 1..255.
REQ-002 SYNC_CYCLES, 4, number of full spi_clk periods that spi_reset stays asserted after reset release.
Ports:
REQ-003 clock  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 in_data  input  16  pixel word to transmit.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle; transfer occurs when in_valid and in_ready are both 1.
REQ-008 spi_clk  output  1  serial clock; idles low; the receiver samples on its rising edge.
REQ-009 spi_mosi  output  1  serial data, MSB first.
REQ-010 spi_reset  output  1  active-high resync to the receiver, which clears its bit counter and held word.
REQ-011 busy  output  1  high while in SYNC or SHIFT.

Function
REQ-012 States: SYNC, IDLE, SHIFT. Reset enters SYNC.
REQ-013 SYNC: spi_reset=1, spi_clk toggles every HALF_PERIOD cycles, spi_mosi=0, in_ready=0.
- After SYNC_CYCLES rising spi_clk edges, the state moves to IDLE and spi_reset falls on the same cycle that spi_clk returns low.
REQ-014 IDLE: spi_clk=0, in_ready=1, and spi_mosi holds its last value.
- On a transfer: load the shift register, set bit index 15, enter SHIFT next cycle.
REQ-015 SHIFT bit timing, per bit:
- spi_clk low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
- spi_mosi changes only on the cycle spi_clk goes low, or on the first SHIFT cycle.
- spi_mosi is stable for the whole high phase.
REQ-016 Latency: with a transfer in cycle N, spi_mosi = in_data[15] from cycle N+1, and the first spi_clk rise is at cycle N+1+HALF_PERIOD.
REQ-017 Each word produces exactly 16 rising spi_clk edges, with bits 15..0 in order.
REQ-018 Back-to-back transfer:
- in_ready=1 on the last cycle of bit 0's high phase.
- If in_valid=1 on that cycle, the next word's bit 15 follows with no idle gap, i.e. a continuous spi_clk.
- Otherwise the state returns to IDLE with spi_clk low.
REQ-019 in_ready=0 on all other SHIFT cycles.
- in_data and in_valid are ignored when in_ready=0.
- The shift register is not altered by input changes mid-word.
REQ-020 The bit index is 4 bits wide; wrap 0->15 occurs only on word reload; no partial words are ever emitted outside reset.
REQ-021 The half-period counter counts 0..HALF_PERIOD-1 and wraps; for HALF_PERIOD=1, spi_clk toggles every cycle.
REQ-022 busy=0 only in IDLE.

Reset
REQ-023 When reset=0 at a clock edge, on the next cycle:
- spi_clk=0, spi_mosi=0, spi_reset=1, in_ready=0, busy=1.
- Counters are zero, the shift register is zero, and the state is SYNC.
REQ-024 Reset mid-word abandons the word immediately with no further spi_clk edges until SYNC begins.
- SYNC then restores receiver alignment.
REQ-025 No output is left undefined (X) after the first reset clock.

Structure
REQ-026 Package hub75_pkg holds PIXEL_WIDTH=16 and the state enumeration (SYNC, IDLE, SHIFT).
- The receiver's word width references the same PIXEL_WIDTH.
REQ-027 Sub-module spi_half_tick holds the half-period counter: inputs clock, reset, enable; output tick (1-cycle pulse every HALF_PERIOD cycles).
- The shift/state logic stays in spi_master_tx.

Verification
REQ-028 Reset release, HALF_PERIOD=2, SYNC_CYCLES=4 -> spi_reset high for exactly 4 spi_clk rises (16 cycles), then IDLE with in_ready=1.
REQ-029 Single word 16'hA5C3 -> the receiver model captures 16'hA5C3 after 16 rises; spi_clk is low and busy=0 afterwards.
REQ-030 Words 16'hFFFF then 16'h0001, in_valid held high -> 32 evenly spaced spi_clk rises with no gap; captured words equal the inputs in order.
REQ-031 HALF_PERIOD=1, word 16'h8000 -> spi_clk toggles every cycle, spi_mosi=1 only during the first bit, latency per REQ-016.
REQ-032 reset=0 after the 7th rise of 16'h1234 -> no further rises before SYNC; receiver word stays 0; next word 16'h00FF captured exactly.
REQ-033 in_data changes mid-word while in_ready=0 -> the transmitted word is unchanged and in_ready is asserted only on bit 0's last high cycle.
